alu_pipe: RTL and testbench

Parametrised, stallable successor to the single-register ALU output stage. It instantiates the combinational `alu` at its input and registers the result through `DEPTH` pipeline stages. Each stage has valid/ready flow control, bubble collapse, flush and an in-flight result lookup port. It sits between the operand-fetch stage and register writeback.

---
 rtl/alu_pipe_pkg.sv | 32 +++
 rtl/alu.sv | 43 ++++
 rtl/alu_pipe_stage.sv | 36 +++
 rtl/alu_pipe.sv | 116 +++++++++++
 tb/tb_alu_pipe.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the pipelined ALU output stage.
package alu_pipe_pkg;

  localparam int unsigned ALU_PIPE_DEPTH_MAX = 8;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned WORD_W             = 32;

  // Opcode field inst[31:28]; unlisted codes produce no register write
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SLT  = 4'd8,
    OP_ADDI = 4'd9,
    OP_LUI  = 4'd10
  } alu_op_e;

  // One pipeline stage record
  typedef struct packed {
    logic                  valid;
    logic                  enable;
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
    logic                  float;
  } stage_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: decodes the instruction word and computes the writeback record.
// Encoding: inst[31:28] opcode, inst[27] FP destination, inst[26:22] destination register.
module alu
  import alu_pipe_pkg::*;
(
  input  logic [WORD_W-1:0]     i_inst,
  input  logic [WORD_W-1:0]     i_rs,
  input  logic [WORD_W-1:0]     i_rt,
  input  logic [WORD_W-1:0]     i_imm,
  output logic                  o_enable_c,
  output logic [REG_ADDR_W-1:0] o_addr_c,
  output logic [WORD_W-1:0]     o_data_c,
  output logic                  o_float_c
);

  alu_op_e w_op;
  logic    w_unused_inst;

  assign w_op          = alu_op_e'(i_inst[31:28]);
  assign o_float_c     = i_inst[27];
  assign o_addr_c      = i_inst[26:22];
  assign w_unused_inst = ^i_inst[21:0];

  // Result and write-enable per opcode
  always_comb begin
    o_enable_c = 1'b1;
    o_data_c   = '0;
    case (w_op)
      OP_ADD:  o_data_c = i_rs + i_rt;
      OP_SUB:  o_data_c = i_rs - i_rt;
      OP_AND:  o_data_c = i_rs & i_rt;
      OP_OR:   o_data_c = i_rs | i_rt;
      OP_XOR:  o_data_c = i_rs ^ i_rt;
      OP_SLL:  o_data_c = i_rs << i_rt[4:0];
      OP_SRL:  o_data_c = i_rs >> i_rt[4:0];
      OP_SLT:  o_data_c = ($signed(i_rs) < $signed(i_rt)) ? WORD_W'(1) : WORD_W'(0);
      OP_ADDI: o_data_c = i_rs + i_imm;
      OP_LUI:  o_data_c = {i_imm[15:0], 16'h0000};
      default: o_enable_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_stage.sv
// One valid/ready register stage; an empty stage always advances so bubbles collapse.
module alu_pipe_stage
  import alu_pipe_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_flush,
  input  stage_t i_up,
  input  logic   i_down_adv,
  output stage_t o_stage,
  output logic   o_adv_c
);

  stage_t r_stage;
  logic   w_adv;

  assign w_adv   = !r_stage.valid || i_down_adv;
  assign o_adv_c = w_adv;
  assign o_stage = r_stage;

  // Capture on transfer, go empty when advancing without one, otherwise hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage <= '0;
    end else if (i_flush) begin
      r_stage.valid <= 1'b0;
    end else if (w_adv) begin
      if (i_up.valid) begin
        r_stage <= i_up;
      end else begin
        r_stage.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Stallable DEPTH-stage ALU result pipeline with flush and in-flight result lookup.
// Optional macro ALU_PIPE_FWD_EN builds the lookup compare; otherwise fwd_hit/fwd_data are 0.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     inst,
  input  logic [WORD_W-1:0]     rs,
  input  logic [WORD_W-1:0]     rt,
  input  logic [WORD_W-1:0]     imm,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  enable,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [WORD_W-1:0]     data,
  output logic                  float,
  output logic                  busy,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  input  logic                  fwd_float,
  output logic                  fwd_hit,
  output logic [WORD_W-1:0]     fwd_data
);

  if (DEPTH < 1 || DEPTH > ALU_PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("alu_pipe: DEPTH out of range");
  end

  logic                  w_alu_enable;
  logic [REG_ADDR_W-1:0] w_alu_addr;
  logic [WORD_W-1:0]     w_alu_data;
  logic                  w_alu_float;
  stage_t                w_up  [DEPTH];
  stage_t                w_stg [DEPTH];
  logic                  w_adv [DEPTH+1];
  logic                  w_busy;
  logic                  w_fwd_hit;
  logic [WORD_W-1:0]     w_fwd_data;

  alu u_alu (
    .i_inst     (inst),
    .i_rs       (rs),
    .i_rt       (rt),
    .i_imm      (imm),
    .o_enable_c (w_alu_enable),
    .o_addr_c   (w_alu_addr),
    .o_data_c   (w_alu_data),
    .o_float_c  (w_alu_float)
  );

  assign w_up[0] = '{valid: in_valid, enable: w_alu_enable, addr: w_alu_addr,
                     data: w_alu_data, float: w_alu_float};
  assign w_adv[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g > 0) begin : g_link
      assign w_up[g] = w_stg[g-1];
    end
    alu_pipe_stage u_stage (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_flush    (flush),
      .i_up       (w_up[g]),
      .i_down_adv (w_adv[g+1]),
      .o_stage    (w_stg[g]),
      .o_adv_c    (w_adv[g])
    );
  end

  // Any stage holding a result
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_busy = w_busy | w_stg[i].valid;
    end
  end

`ifdef ALU_PIPE_FWD_EN
  logic w_lookup_ok;
  assign w_lookup_ok = fwd_float || (fwd_addr != '0);

  // Scan oldest to youngest so the youngest match overwrites
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_lookup_ok && w_stg[i].valid && w_stg[i].enable &&
          (w_stg[i].float == fwd_float) && (w_stg[i].addr == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_stg[i].data;
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_addr, fwd_float};
  assign w_fwd_hit    = 1'b0;
  assign w_fwd_data   = '0;
`endif

  assign in_ready  = w_adv[0];
  assign out_valid = w_stg[DEPTH-1].valid;
  assign enable    = w_stg[DEPTH-1].enable;
  assign addr      = w_stg[DEPTH-1].addr;
  assign data      = w_stg[DEPTH-1].data;
  assign float     = w_stg[DEPTH-1].float;
  assign busy      = w_busy;
  assign fwd_hit   = w_fwd_hit;
  assign fwd_data  = w_fwd_data;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DEPTH=3): directed scenarios plus randomized traffic
// against an occupancy-based reference model.
module tb_alu_pipe;

  localparam int unsigned DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst, rs, rt, imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        enable;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        float;
  logic        busy;
  logic [4:0]  fwd_addr;
  logic        fwd_float;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  alu_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs(rs), .rt(rt), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .enable(enable), .addr(addr),
    .data(data), .float(float), .busy(busy), .fwd_addr(fwd_addr),
    .fwd_float(fwd_float), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  typedef struct packed {
    logic        v;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic        f;
  } rec_t;

  rec_t m_slot [DEPTH];
  rec_t m_last;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of one instruction
  function automatic rec_t ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im);
    rec_t r;
    r.v  = 1'b1;
    r.f  = ins[27];
    r.a  = ins[26:22];
    r.en = 1'b1;
    r.d  = 32'd0;
    case (ins[31:28])
      4'd1:  r.d = a + b;
      4'd2:  r.d = a - b;
      4'd3:  r.d = a & b;
      4'd4:  r.d = a | b;
      4'd5:  r.d = a ^ b;
      4'd6:  r.d = a << b[4:0];
      4'd7:  r.d = a >> b[4:0];
      4'd8:  r.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r.d = a + im;
      4'd10: r.d = im << 16;
      default: r.en = 1'b0;
    endcase
    return r;
  endfunction

  // The pipe accepts unless every slot is occupied and nothing leaves
  function automatic logic exp_in_ready();
    int n = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (m_slot[i].v) n++;
    return (n < int'(DEPTH)) || out_ready;
  endfunction

  function automatic logic [32:0] exp_fwd();
    logic [32:0] res = 33'd0;
`ifdef ALU_PIPE_FWD_EN
    logic found = 1'b0;
    if (fwd_float || fwd_addr != 5'd0) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!found && m_slot[i].v && m_slot[i].en && m_slot[i].f == fwd_float &&
            m_slot[i].a == fwd_addr) begin
          found = 1'b1;
          res   = {1'b1, m_slot[i].d};
        end
      end
    end
`endif
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_slot[i] = '0;
    m_last = '0;
  endtask

  // Clock edge: drop on flush, else retire, slide results into holes, then accept
  task automatic model_edge();
    logic acc;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) m_slot[i].v = 1'b0;
    end else begin
      acc = in_valid && exp_in_ready();
      if (m_slot[DEPTH-1].v && out_ready) m_slot[DEPTH-1].v = 1'b0;
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        if (!m_slot[i].v) begin
          m_slot[i]     = m_slot[i-1];
          m_slot[i-1].v = 1'b0;
        end
      end
      if (acc) m_slot[0] = ref_alu(inst, rs, rt, imm);
      if (m_slot[DEPTH-1].v) m_last = m_slot[DEPTH-1];
    end
  endtask

  task automatic compare_all();
    logic [32:0] f;
    logic        any;
    f   = exp_fwd();
    any = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) any = any | m_slot[i].v;
    check_eq("in_ready",  in_ready,  exp_in_ready());
    check_eq("out_valid", out_valid, m_slot[DEPTH-1].v);
    check_eq("enable",    enable,    m_last.en);
    check_eq("addr",      addr,      m_last.a);
    check_eq("data",      data,      m_last.d);
    check_eq("float",     float,     m_last.f);
    check_eq("busy",      busy,      any);
    check_eq("fwd_hit",   fwd_hit,   f[32]);
    check_eq("fwd_data",  fwd_data,  f[31:0]);
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ii, input logic [31:0] irs,
                       input logic [31:0] irt, input logic [31:0] iim,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    inst      = ii;
    rs        = irs;
    rt        = irt;
    imm       = iim;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [3:0] op, input logic fb,
                                          input logic [4:0] rd);
    return {op, fb, rd, 22'd0};
  endfunction

  logic        acc, pend;
  int          k;
  logic [31:0] p_inst, p_rs, p_rt, p_imm;
  logic [3:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_fb;

  initial begin
    reset = 1'b1; in_valid = 1'b0; inst = '0; rs = '0; rt = '0; imm = '0;
    flush = 1'b0; out_ready = 1'b0; fwd_addr = '0; fwd_float = 1'b0;
    model_reset();
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_enable", enable, 0);

    // ADD r3 = 5 + 7 appears exactly DEPTH edges after being offered
    cycle(1'b1, mk_inst(4'd1, 1'b0, 5'd3), 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
    check_eq("lat_edge1_ov", out_valid, 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check_eq("lat_edge2_ov", out_valid, 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check_eq("lat_ov", out_valid, 1);
    check_eq("lat_data", data, 12);
    check_eq("lat_addr", addr, 3);
    check_eq("lat_enable", enable, 1);
    check_eq("lat_float", float, 0);
    repeat (2) cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

    // Back-to-back inputs into a stalled pipe, then drain in order
    k = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready = 1'b0;
      acc = exp_in_ready();
      cycle(1'b1, mk_inst(4'd1, 1'b0, 5'(k + 1)), 32'(100 + k), 32'd1, 32'd0, 1'b0, 1'b0);
      if (acc) k++;
    end
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_head_data", data, 101);
    for (int c = 0; c < 8; c++) begin
      out_ready = 1'b1;
      acc = exp_in_ready();
      cycle(k < 4, mk_inst(4'd1, 1'b0, 5'(k + 1)), 32'(100 + k), 32'd1, 32'd0, 1'b1, 1'b0);
      if (acc && k < 4) k++;
    end
    check_eq("drain_busy", busy, 0);

    // Bubble at stage 0 of a stalled pipe is refilled from the input
    cycle(1'b1, mk_inst(4'd2, 1'b0, 5'd7), 32'd50, 32'd8, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, mk_inst(4'd4, 1'b1, 5'd6), 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("bubble_in_ready", in_ready, 1);
    cycle(1'b1, mk_inst(4'd10, 1'b0, 5'd9), 32'd0, 32'd0, 32'h1234, 1'b0, 1'b0);
    check_eq("refill_in_ready", in_ready, 0);
    check_eq("refill_busy", busy, 1);

    // Flush with every stage valid and input offered
    cycle(1'b1, mk_inst(4'd1, 1'b0, 5'd5), 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
    check_eq("flush_busy", busy, 0);
    check_eq("flush_ov", out_valid, 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("flush_dropped", busy, 0);

    // Lookup: stage0 r4=9, stage1 r4=2
    cycle(1'b1, mk_inst(4'd9, 1'b0, 5'd4), 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, mk_inst(4'd9, 1'b0, 5'd4), 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    fwd_addr = 5'd4; fwd_float = 1'b0; #1;
`ifdef ALU_PIPE_FWD_EN
    check_eq("fwd_young_hit", fwd_hit, 1);
    check_eq("fwd_young_data", fwd_data, 9);
`else
    check_eq("fwd_off_hit", fwd_hit, 0);
    check_eq("fwd_off_data", fwd_data, 0);
`endif
    fwd_addr = 5'd0; #1;
    check_eq("fwd_r0_hit", fwd_hit, 0);
    check_eq("fwd_r0_data", fwd_data, 0);

    // Asynchronous reset between edges with two valid stages
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("pre_rst_ov", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_data", data, 0);
    reset = 1'b0;
    model_reset();
    cycle(1'b1, mk_inst(4'd3, 1'b0, 5'd12), 32'hFF00, 32'h0FF0, 32'd0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check_eq("post_rst_ov", out_valid, 1);
    check_eq("post_rst_data", data, 32'h0F00);

    // Randomized traffic: operands held stable until accepted
    pend = 1'b0;
    p_inst = '0; p_rs = '0; p_rt = '0; p_imm = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend   = 1'b1;
        r_op   = 4'($urandom_range(0, 12));
        r_fb   = 1'($urandom_range(0, 1));
        r_rd   = 5'($urandom_range(0, 7));
        p_inst = {r_op, r_fb, r_rd, 22'($urandom)};
        p_rs   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        p_rt   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        p_imm  = $urandom;
      end
      fwd_addr  = 5'($urandom_range(0, 7));
      fwd_float = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      acc = pend && exp_in_ready();
      cycle(pend, p_inst, p_rs, p_rt, p_imm, out_ready, flush);
      if (acc || flush) pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
